// File: rtl/txuart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : txuart_fifo
// Brief    : FIFO-buffered UART transmitter. Bytes enter through a
//            strobe/busy handshake into a circular buffer and are serialized
//            LSB first onto an idle-high TX line, one start bit, eight data
//            bits, one stop bit, with no gap between queued frames.
// Options  : define TXUART_PARITY_EN to insert an even-parity bit between
//            the data bits and the stop bit (11 bit periods per frame).
// Revision : 1.0 - initial release
// ============================================================================
module txuart_fifo #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250,
  parameter int unsigned LGFIFO          = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  output logic              o_busy,
  output logic              o_uart_tx,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_idle
);

  localparam int unsigned     c_depth     = 1 << LGFIFO;
  localparam logic [LGFIFO:0] c_full      = (LGFIFO + 1)'(c_depth);
  localparam logic [LGFIFO:0] c_fill_one  = (LGFIFO + 1)'(1);
  localparam logic [LGFIFO-1:0] c_ptr_one = LGFIFO'(1);
  localparam logic [23:0]     c_baud_last = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef TXUART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [c_depth];
  logic [LGFIFO-1:0] wr_ptr_q;
  logic [LGFIFO-1:0] rd_ptr_q;
  logic [LGFIFO:0]   fill_q;

  // Serializer registers
  state_t      state_q, state_d;
  logic [23:0] baud_q,  baud_d;
  logic [2:0]  bit_q,   bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q,   par_d;
  logic        tx_q,    tx_d;

  logic        w_accept;
  logic        w_pop;
  logic        w_tick;
  logic        w_have;
  logic [7:0]  w_head;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign o_busy   = (fill_q == c_full);
  assign w_accept = i_wr && !o_busy;
  assign w_have   = (fill_q != '0);
  assign w_head   = mem_q[rd_ptr_q];
  assign w_tick   = (baud_q == 24'd0);

  assign o_fill    = fill_q;
  assign o_uart_tx = tx_q;
  assign o_idle    = (state_q == S_IDLE) && (fill_q == '0);

  // Byte storage; contents need no reset since pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leave fill alone.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (w_accept) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_one;
      end
      case ({w_accept, w_pop})
        2'b10:   fill_q <= fill_q + c_fill_one;
        2'b01:   fill_q <= fill_q - c_fill_one;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Serializer state register; reset abandons any frame and drives the line high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= 24'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: bit boundaries fall where the baud counter hits zero.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    w_pop   = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = w_tick ? c_baud_last : (baud_q - 24'd1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (w_have) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          par_d   = ^w_head;
          baud_d  = c_baud_last;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (w_tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      S_DATA: begin
        if (w_tick) begin
          if (bit_q == 3'd7) begin
`ifdef TXUART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end

`ifdef TXUART_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_tick) begin
          // Chain straight into the next start bit when data is waiting.
          if (w_have) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            par_d   = ^w_head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
